// File: rtl/rmap_status_collector.sv
// Status/error collector for a multi-channel RMAP target: per-channel event counters,
// sticky error flags and a round-robin fed error-event FIFO for housekeeping.
module rmap_status_collector #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [NUM_CH-1:0]             write_ind,
    input  logic [NUM_CH-1:0]             read_ind,
    input  logic [NUM_CH-1:0]             rmw_ind,
    input  logic [NUM_CH-1:0]             error_ind,
    input  logic [8*NUM_CH-1:0]           error_code,
    input  logic [NUM_CH-1:0]             addr_invalid,
    input  logic [NUM_CH-1:0]             len_invalid,
    input  logic [CH_W-1:0]               cnt_ch,
    input  logic [2:0]                    cnt_sel,
    output logic [CNT_W-1:0]              cnt_value,
    output logic [NUM_CH-1:0]             sticky_err,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [CH_W-1:0]               evt_ch,
    output logic [7:0]                    evt_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              drop_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int NUM_EV = 6;
    localparam int EV_ERR = 3;
    localparam int ENT_W  = CH_W + 8;

    logic [NUM_CH-1:0] ind_s  [NUM_EV];
    logic [NUM_CH-1:0] prev_r [NUM_EV];
    logic [NUM_CH-1:0] rise_s [NUM_EV];
    logic [CNT_W-1:0]  cnt_r  [NUM_EV][NUM_CH];

    logic [NUM_CH-1:0] pend_r;
    logic [7:0]        pcode_r [NUM_CH];
    logic [CH_W-1:0]   rr_ptr_r;
    logic [NUM_CH-1:0] sticky_r;
    logic [CNT_W-1:0]  drop_cnt_r;

    logic [ENT_W-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  rd_nxt_s;
    logic [LVL_W-1:0]  level_r;
    logic [LVL_W-1:0]  level_nxt_s;
    logic              evt_valid_r;
    logic [ENT_W-1:0]  head_r;
    logic [ENT_W-1:0]  head_s;

    int                arb_idx_s;
    logic              push_found_s;
    logic [CH_W-1:0]   push_ch_s;
    logic [CH_W-1:0]   rr_nxt_s;
    logic [ENT_W-1:0]  push_data_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic [NUM_CH-1:0] push_hit_s;
    logic [NUM_CH-1:0] drop_s;
    logic [CNT_W:0]    drop_sum_s;
    logic [CNT_W-1:0]  sel_s;
    logic [CNT_W-1:0]  cnt_value_r;

    assign ind_s[0] = write_ind;
    assign ind_s[1] = read_ind;
    assign ind_s[2] = rmw_ind;
    assign ind_s[3] = error_ind;
    assign ind_s[4] = addr_invalid;
    assign ind_s[5] = len_invalid;

    // Rising-edge detection against the previous-cycle sample
    always_comb begin
        for (int k = 0; k < NUM_EV; k++) begin
            rise_s[k] = ind_s[k] & ~prev_r[k];
        end
    end

    // Round-robin search for the first pending slot starting at the pointer
    always_comb begin
        push_found_s = 1'b0;
        push_ch_s    = '0;
        arb_idx_s    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            arb_idx_s = int'(rr_ptr_r) + k;
            arb_idx_s = (arb_idx_s >= NUM_CH) ? (arb_idx_s - NUM_CH) : arb_idx_s;
            if (!push_found_s && pend_r[arb_idx_s]) begin
                push_found_s = 1'b1;
                push_ch_s    = CH_W'(arb_idx_s);
            end else begin
                push_found_s = push_found_s;
            end
        end
    end

    // Push/pop qualification; a full FIFO still accepts a push while it is being popped
    always_comb begin
        full_s      = (level_r == LVL_W'(FIFO_DEPTH));
        pop_s       = evt_valid_r && evt_ready && !clear;
        push_s      = push_found_s && (!full_s || pop_s) && !clear;
        push_data_s = {push_ch_s, pcode_r[push_ch_s]};
        rr_nxt_s    = (push_ch_s == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : (push_ch_s + CH_W'(1));
        for (int i = 0; i < NUM_CH; i++) begin
            push_hit_s[i] = push_s && (push_ch_s == CH_W'(i));
            drop_s[i]     = rise_s[EV_ERR][i] && pend_r[i] && !push_hit_s[i] && !clear;
        end
    end

    // Total of simultaneous drops added to the running drop count
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_r};
        for (int i = 0; i < NUM_CH; i++) begin
            drop_sum_s = drop_sum_s + {{CNT_W{1'b0}}, drop_s[i]};
        end
    end

    // Next FIFO head; bypass the write when the pushed entry lands at the new read slot
    always_comb begin
        level_nxt_s = level_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
        rd_nxt_s    = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        if (level_nxt_s == {LVL_W{1'b0}}) begin
            head_s = '0;
        end else if (push_s && (wr_ptr_r == rd_nxt_s)) begin
            head_s = push_data_s;
        end else begin
            head_s = mem_r[rd_nxt_s];
        end
    end

    // Counter readout mux; unused selects and channels fall through to zero
    always_comb begin
        sel_s = '0;
        for (int s = 0; s < NUM_EV; s++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sel_s = sel_s | (((cnt_sel == 3'(s)) && (cnt_ch == CH_W'(c))) ? cnt_r[s][c] : {CNT_W{1'b0}});
            end
        end
    end

    // Edge-detect history, kept running through clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_EV; k++) prev_r[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_EV; k++) prev_r[k] <= ind_s[k];
        end
    end

    // Saturating per-channel event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_EV; k++)
                for (int c = 0; c < NUM_CH; c++) cnt_r[k][c] <= '0;
        end else if (clear) begin
            for (int k = 0; k < NUM_EV; k++)
                for (int c = 0; c < NUM_CH; c++) cnt_r[k][c] <= '0;
        end else begin
            for (int k = 0; k < NUM_EV; k++)
                for (int c = 0; c < NUM_CH; c++)
                    if (rise_s[k][c] && (cnt_r[k][c] != {CNT_W{1'b1}}))
                        cnt_r[k][c] <= cnt_r[k][c] + CNT_W'(1);
        end
    end

    // Pending slots, sticky flags, arbiter pointer and drop count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r     <= '0;
            sticky_r   <= '0;
            rr_ptr_r   <= '0;
            drop_cnt_r <= '0;
            for (int i = 0; i < NUM_CH; i++) pcode_r[i] <= 8'h00;
        end else if (clear) begin
            pend_r     <= '0;
            sticky_r   <= '0;
            rr_ptr_r   <= '0;
            drop_cnt_r <= '0;
            for (int i = 0; i < NUM_CH; i++) pcode_r[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rise_s[EV_ERR][i] && (!pend_r[i] || push_hit_s[i])) begin
                    pend_r[i]  <= 1'b1;
                    pcode_r[i] <= error_code[8*i +: 8];
                end else if (push_hit_s[i]) begin
                    pend_r[i]  <= 1'b0;
                end
            end
            sticky_r   <= sticky_r | rise_s[EV_ERR];
            if (push_s) rr_ptr_r <= rr_nxt_s;
            drop_cnt_r <= drop_sum_s[CNT_W] ? {CNT_W{1'b1}} : drop_sum_s[CNT_W-1:0];
        end
    end

    // FIFO pointers, occupancy and registered head outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            evt_valid_r <= 1'b0;
            head_r      <= '0;
        end else if (clear) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            evt_valid_r <= 1'b0;
            head_r      <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            rd_ptr_r    <= rd_nxt_s;
            level_r     <= level_nxt_s;
            evt_valid_r <= (level_nxt_s != {LVL_W{1'b0}});
            head_r      <= head_s;
        end
    end

    // FIFO storage; contents are only observed through the pointers
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= push_data_s;
    end

    // Registered counter readout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_value_r <= '0;
        else        cnt_value_r <= sel_s;
    end

    assign cnt_value  = cnt_value_r;
    assign sticky_err = sticky_r;
    assign evt_valid  = evt_valid_r;
    assign evt_ch     = head_r[ENT_W-1:8];
    assign evt_code   = head_r[7:0];
    assign fifo_level = level_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_rmap_status_collector.sv
// Self-checking bench for rmap_status_collector: counter tables plus a scoreboard
// of expected error events compared as the FIFO drains.
module tb_rmap_status_collector;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CH_W       = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic [3:0]        write_ind, read_ind, rmw_ind, error_ind, addr_invalid, len_invalid;
    logic [31:0]       error_code;
    logic [1:0]        cnt_ch;
    logic [2:0]        cnt_sel;
    logic [3:0]        cnt_value;
    logic [3:0]        sticky_err;
    logic              evt_valid;
    logic              evt_ready;
    logic [1:0]        evt_ch;
    logic [7:0]        evt_code;
    logic [3:0]        fifo_level;
    logic [3:0]        drop_cnt;

    typedef struct {
        logic [2:0] sel;
        logic [1:0] ch;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] code;
    } ev_t;

    ev_t  sb[$];
    vec_t tbl1[10];
    vec_t tbl2[8];
    int   errors = 0;
    int   checks = 0;

    rmap_status_collector #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .write_ind(write_ind), .read_ind(read_ind), .rmw_ind(rmw_ind),
        .error_ind(error_ind), .error_code(error_code),
        .addr_invalid(addr_invalid), .len_invalid(len_invalid),
        .cnt_ch(cnt_ch), .cnt_sel(cnt_sel), .cnt_value(cnt_value),
        .sticky_err(sticky_err), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_ch(evt_ch), .evt_code(evt_code), .fifo_level(fifo_level),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_cnt(input string name, input logic [2:0] sel, input logic [1:0] ch,
                            input logic [3:0] exp);
        cnt_sel = sel;
        cnt_ch  = ch;
        tick();
        check($sformatf("%s_s%0d_c%0d", name, sel, ch), cnt_value, exp);
    endtask

    task automatic pop_check(input string name);
        int  n;
        ev_t e;
        n = 0;
        while (evt_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (evt_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: evt_valid stayed %b, expected 1", name, evt_valid);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_extra: unexpected entry ch=%0d code=%0h", name, evt_ch, evt_code);
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end else begin
            e = sb.pop_front();
            check({name, "_ch"}, evt_ch, e.ch);
            check({name, "_code"}, evt_code, e.code);
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end
    endtask

    initial begin
        tbl1[0] = '{3'd0, 2'd1, 4'd1};  tbl1[1] = '{3'd0, 2'd0, 4'd0};
        tbl1[2] = '{3'd0, 2'd2, 4'd0};  tbl1[3] = '{3'd1, 2'd1, 4'd0};
        tbl1[4] = '{3'd2, 2'd1, 4'd0};  tbl1[5] = '{3'd3, 2'd1, 4'd0};
        tbl1[6] = '{3'd4, 2'd1, 4'd0};  tbl1[7] = '{3'd5, 2'd1, 4'd0};
        tbl1[8] = '{3'd6, 2'd1, 4'd0};  tbl1[9] = '{3'd7, 2'd1, 4'd0};
        tbl2[0] = '{3'd2, 2'd0, 4'd15}; tbl2[1] = '{3'd1, 2'd0, 4'd1};
        tbl2[2] = '{3'd4, 2'd3, 4'd2};  tbl2[3] = '{3'd5, 2'd2, 4'd3};
        tbl2[4] = '{3'd3, 2'd0, 4'd3};  tbl2[5] = '{3'd3, 2'd3, 4'd5};
        tbl2[6] = '{3'd0, 2'd1, 4'd0};  tbl2[7] = '{3'd6, 2'd0, 4'd0};

        rst_n = 1'b0; clear = 1'b0; evt_ready = 1'b0;
        write_ind = '0; read_ind = '0; rmw_ind = '0; error_ind = '0;
        addr_invalid = '0; len_invalid = '0; error_code = '0;
        cnt_ch = 2'd0; cnt_sel = 3'd0;
        repeat (3) tick();
        check("rst_level", fifo_level, 4'd0);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_evt_ch", evt_ch, 2'd0);
        check("rst_evt_code", evt_code, 8'h00);
        check("rst_sticky", sticky_err, 4'b0000);
        check("rst_drop", drop_cnt, 4'd0);
        check("rst_cnt_value", cnt_value, 4'd0);
        rst_n = 1'b1;
        tick();

        // held write level counts once
        write_ind[1] = 1'b1;
        repeat (5) tick();
        write_ind[1] = 1'b0;
        tick();
        foreach (tbl1[i]) read_cnt("t1", tbl1[i].sel, tbl1[i].ch, tbl1[i].exp);
        check("t1_valid", evt_valid, 1'b0);

        // single error: two posedges to evt_valid
        error_code[23:16] = 8'h0A;
        error_ind[2] = 1'b1;
        sb.push_back('{2'd2, 8'h0A});
        tick();
        check("t2_valid_n", evt_valid, 1'b0);
        tick();
        check("t2_valid_n1", evt_valid, 1'b1);
        check("t2_sticky", sticky_err, 4'b0100);
        pop_check("t2_pop");
        check("t2_level", fifo_level, 4'd0);
        check("t2_valid_after", evt_valid, 1'b0);
        error_ind = '0;
        tick();

        // clear restarts the arbiter at channel 0
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int c = 0; c < 4; c++) begin
            error_code[8*c +: 8] = 8'(c + 1);
            sb.push_back('{2'(c), 8'(c + 1)});
        end
        error_ind = 4'hF;
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t3_level%0d", k), fifo_level, 4'(k));
        end
        check("t3_sticky", sticky_err, 4'hF);
        for (int k = 0; k < 4; k++) pop_check($sformatf("t3_pop%0d", k));
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("t3_ready_empty", fifo_level, 4'd0);

        // fill FIFO to 8 with two batches
        error_ind = '0;
        tick();
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 4; c++) begin
                error_code[8*c +: 8] = 8'h11 + 8'(16 * b + c);
                sb.push_back('{2'(c), 8'h11 + 8'(16 * b + c)});
            end
            error_ind = 4'hF;
            repeat (5) tick();
            error_ind = '0;
            tick();
        end
        check("t4_full", fifo_level, 4'd8);
        error_code[31:24] = 8'h33;
        error_ind = 4'b1000;
        sb.push_back('{2'd3, 8'h33});
        tick();
        error_ind = '0;
        tick();
        check("t4_no_drop", drop_cnt, 4'd0);
        error_code[31:24] = 8'h44;
        error_ind = 4'b1000;
        tick();
        check("t4_drop", drop_cnt, 4'd1);
        check("t4_level_held", fifo_level, 4'd8);
        error_ind = '0;
        pop_check("t4_pop_first");
        tick();
        check("t4_level_after_pop", fifo_level, 4'd8);
        while (sb.size() > 0) pop_check("t4_drain");
        check("t4_level_empty", fifo_level, 4'd0);

        // saturation and mixed counters
        for (int i = 0; i < 20; i++) begin
            rmw_ind[0]      = 1'b1;
            read_ind[0]     = (i == 0);
            addr_invalid[3] = (i < 2);
            len_invalid[2]  = (i < 3);
            tick();
            rmw_ind = '0; read_ind = '0; addr_invalid = '0; len_invalid = '0;
            tick();
        end
        foreach (tbl2[i]) read_cnt("t5", tbl2[i].sel, tbl2[i].ch, tbl2[i].exp);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int s = 0; s < 6; s++)
            for (int c = 0; c < 4; c++) read_cnt("t5_clr", 3'(s), 2'(c), 4'd0);
        check("t5_clr_sticky", sticky_err, 4'b0000);
        check("t5_clr_drop", drop_cnt, 4'd0);

        // reset mid-stream
        for (int c = 0; c < 3; c++) error_code[8*c +: 8] = 8'h61 + 8'(c);
        error_ind = 4'b0111;
        repeat (4) tick();
        check("t6_queued", fifo_level, 4'd3);
        rst_n = 1'b0;
        error_ind = '0;
        #1;
        check("t6_rst_level", fifo_level, 4'd0);
        check("t6_rst_valid", evt_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        error_code[15:8] = 8'h5A;
        error_ind[1] = 1'b1;
        sb.push_back('{2'd1, 8'h5A});
        tick();
        tick();
        check("t6_level_one", fifo_level, 4'd1);
        pop_check("t6_pop");
        check("t6_level_end", fifo_level, 4'd0);
        check("t6_valid_end", evt_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
